// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_e;

    localparam int         DEF_MAX_LEN   = 8;
    localparam int         DEF_CNT_W     = 8;
    localparam logic [7:0] DEF_PATTERN_C = 8'h0D;
    localparam int         DEF_LEN_C     = 4;
    localparam bit         DEF_OVERLAP_C = 1'b1;

    // Width needed to hold a pattern length in 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// Serial history shift register: newest bit enters at q_o[0].
module seq_hist_shreg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         d_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] nxt_o
);

    logic [W-1:0] q_q;

    // Shifted value is exported so the comparator sees the incoming bit this cycle.
    assign nxt_o = {q_q[W-2:0], d_i};
    assign q_o   = q_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= nxt_o;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Mealy serial pattern detector with programmable pattern, length and overlap,
// registered match pulse and saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               MAX_LEN     = DEF_MAX_LEN,
    parameter int               CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
    parameter int               DEF_LEN     = DEF_LEN_C,
    parameter bit               DEF_OVERLAP = DEF_OVERLAP_C,
    localparam int              LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic [MAX_LEN-1:0] out,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    localparam state_e RST_STATE = (DEF_LEN <= 1) ? ARMED : FILL;

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic               err_q;
    logic [LEN_W-1:0]   fill_q, fill_d;
    state_e             state_q, state_d;
    logic               z_q, z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               cfg_legal;
    logic               accept;
    logic               match;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] cmp_mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_sat;

    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign accept    = in_valid && !cfg_load && (state_q != IDLE);

    seq_hist_shreg #(.W(MAX_LEN)) u_hist (
        .clk_i (clk),
        .clr_i (reset || cfg_load),
        .en_i  (accept),
        .d_i   (in),
        .q_o   (out),
        .nxt_o (hist_n)
    );

    always_comb begin
        cmp_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            cmp_mask[i] = (i < int'(len_q));
        end
    end

    // ARMED tracks fill >= len-1, so the state alone qualifies a compare.
    assign match = accept && (state_q == ARMED) &&
                   (((hist_n ^ pat_q) & cmp_mask) == '0);

    assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
    assign fill_sat = (fill_inc > {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];

    always_comb begin
        fill_d  = fill_q;
        state_d = state_q;
        z_d     = 1'b0;
        if (cfg_load) begin
            fill_d = '0;
            if (!cfg_legal) begin
                state_d = IDLE;
            end else if (cfg_len == LEN_W'(1)) begin
                state_d = ARMED;
            end else begin
                state_d = FILL;
            end
        end else if (accept) begin
            z_d    = match;
            fill_d = (match && !ovl_q) ? '0 : fill_sat;
            state_d = (fill_d >= len_q - LEN_W'(1)) ? ARMED : FILL;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_STATE;
            fill_q  <= '0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
        end
    end

    // An illegal load keeps the previous config; only the error flag changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q <= DEF_PATTERN;
            len_q <= LEN_W'(DEF_LEN);
            ovl_q <= DEF_OVERLAP;
            err_q <= 1'b0;
        end else if (cfg_load) begin
            if (cfg_legal) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
                err_q <= 1'b0;
            end else begin
                err_q <= 1'b1;
            end
        end
    end

    assign z           = z_q;
    assign match_count = cnt_q;
    assign armed       = (state_q == ARMED);
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed bit streams, expected
// response queued per cycle, popped and checked by an independent monitor.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset, in_valid, din, cfg_load, cfg_overlap, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       z, armed, cfg_err;
    logic [7:0] out;
    logic [1:0] match_count;

    typedef struct {
        logic z;
        int   cnt;
        logic err;
        int   hist;
        int   id;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_step = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in          (din),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .z           (z),
        .out         (out),
        .match_count (match_count),
        .armed       (armed),
        .cfg_err     (cfg_err)
    );

    task automatic step(input logic r, input logic v, input logic b, input logic ld,
                        input logic clr, input logic ez, input int ecnt,
                        input logic eerr, input int eh);
        exp_t e;
        @(negedge clk);
        reset    = r;
        in_valid = v;
        din      = b;
        cfg_load = ld;
        cnt_clr  = clr;
        e.z = ez; e.cnt = ecnt; e.err = eerr; e.hist = eh; e.id = n_step;
        sb.push_back(e);
        n_step++;
    endtask

    // Monitor: one response per clock edge that followed a queued stimulus.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (z !== e.z) begin
                n_fail++;
                $display("FAIL z step %0d: got %0b want %0b", e.id, z, e.z);
            end
            n_chk++;
            if (int'(match_count) != e.cnt || $isunknown(match_count)) begin
                n_fail++;
                $display("FAIL match_count step %0d: got %0d want %0d", e.id, match_count, e.cnt);
            end
            n_chk++;
            if (cfg_err !== e.err) begin
                n_fail++;
                $display("FAIL cfg_err step %0d: got %0b want %0b", e.id, cfg_err, e.err);
            end
            if (e.hist >= 0) begin
                n_chk++;
                if (out !== 8'(e.hist)) begin
                    n_fail++;
                    $display("FAIL out step %0d: got %h want %h", e.id, out, 8'(e.hist));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; din = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;

        // reset state, then reset beats a valid bit
        step(1,0,0,0,0, 0,0,0,'h00);
        step(1,1,1,0,0, 0,0,0,'h00);

        // T1: default 1101 overlapping
        step(0,1,1,0,0, 0,0,0,-1);
        step(0,1,1,0,0, 0,0,0,-1);
        step(0,1,0,0,0, 0,0,0,-1);
        step(0,1,1,0,0, 1,1,0,'h0D);
        step(0,1,1,0,0, 0,1,0,-1);
        step(0,1,0,0,0, 0,1,0,-1);
        step(0,1,1,0,0, 1,2,0,'h6D);
        step(0,0,0,0,1, 0,0,0,'h6D);

        // T2: 101 non-overlapping; bit on the load edge is dropped
        cfg_len = 4'd3; cfg_pattern = 8'b101; cfg_overlap = 1'b0;
        step(0,1,1,1,0, 0,0,0,'h00);
        step(0,1,1,0,0, 0,0,0,-1);
        step(0,1,0,0,0, 0,0,0,-1);
        step(0,1,1,0,0, 1,1,0,-1);
        step(0,1,0,0,0, 0,1,0,-1);
        step(0,1,1,0,0, 0,1,0,'h15);
        step(0,0,0,0,1, 0,0,0,-1);

        // T3: 101 overlapping
        cfg_overlap = 1'b1;
        step(0,0,0,1,0, 0,0,0,'h00);
        step(0,1,1,0,0, 0,0,0,-1);
        step(0,1,0,0,0, 0,0,0,-1);
        step(0,1,1,0,0, 1,1,0,-1);
        step(0,1,0,0,0, 0,1,0,-1);
        step(0,1,1,0,0, 1,2,0,'h15);
        step(0,0,0,0,1, 0,0,0,-1);

        // T4: in_valid gaps carry zeros that must not be shifted in
        step(0,1,1,0,0, 0,0,0,-1);
        step(0,0,0,0,0, 0,0,0,-1);
        step(0,1,0,0,0, 0,0,0,-1);
        step(0,0,0,0,0, 0,0,0,-1);
        step(0,0,0,0,0, 0,0,0,-1);
        step(0,1,1,0,0, 1,1,0,'hAD);
        step(0,0,1,0,0, 0,1,0,'hAD);
        step(0,0,0,0,1, 0,0,0,-1);

        // T5: illegal length, then recovery
        cfg_len = 4'd0;
        step(0,0,0,1,0, 0,0,1,'h00);
        step(0,1,1,0,0, 0,0,1,'h00);
        step(0,1,0,0,0, 0,0,1,'h00);
        step(0,1,1,0,0, 0,0,1,'h00);
        cfg_len = 4'd9;
        step(0,0,0,1,0, 0,0,1,'h00);
        step(0,1,1,0,0, 0,0,1,'h00);
        cfg_len = 4'd3; cfg_pattern = 8'b101; cfg_overlap = 1'b1;
        step(0,0,0,1,0, 0,0,0,'h00);
        step(0,1,1,0,0, 0,0,0,-1);
        step(0,1,0,0,0, 0,0,0,-1);
        step(0,1,1,0,0, 1,1,0,'h05);

        // T6: saturation, clear beats match, reset mid-pattern
        step(0,1,0,0,0, 0,1,0,-1);
        step(0,1,1,0,0, 1,2,0,-1);
        step(0,1,0,0,0, 0,2,0,-1);
        step(0,1,1,0,0, 1,3,0,-1);
        step(0,1,0,0,0, 0,3,0,-1);
        step(0,1,1,0,0, 1,3,0,-1);
        step(0,1,0,0,0, 0,3,0,-1);
        step(0,1,1,0,1, 1,0,0,-1);
        step(0,1,1,0,0, 0,0,0,-1);
        step(0,1,0,0,0, 0,0,0,-1);
        step(1,1,1,0,0, 0,0,0,'h00);
        step(0,1,1,0,0, 0,0,0,'h01);
        step(0,1,1,0,0, 0,0,0,-1);
        step(0,1,0,0,0, 0,0,0,-1);
        step(0,1,1,0,0, 1,1,0,'h0D);
        step(0,0,0,0,0, 0,1,0,'h0D);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
